// File: rtl/mod_issue_ctrl.sv
// Issue/stall controller in front of the multi-cycle modulo unit.
// Optional BUSY watchdog: define MOD_TIMEOUT_EN.
module mod_issue_ctrl #(
  parameter int WIDTH         = 32,
  parameter int LAUNCH_CYCLES = 1,
  parameter int TIMEOUT       = 1024
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic             unit_rst,
  input  logic             unit_done,
  input  logic [WIDTH-1:0] unit_result,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] rem_q,
  output logic             rem_valid,
  output logic             dbz,
  output logic             timeout_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] BUSY   = 2'd2;

  localparam int LW = $clog2(LAUNCH_CYCLES + 1);
  localparam logic [LW-1:0] L_LAST = LW'(LAUNCH_CYCLES - 1);

  logic [1:0]    state_q;
  logic [LW-1:0] lcnt_q;
  logic          is_idle;
  logic          is_launch;
  logic          is_busy;
  logic          accept;
  logic          rt_nz;
  logic          tmo;

  assign is_idle   = (state_q == IDLE);
  assign is_launch = (state_q == LAUNCH);
  assign is_busy   = (state_q == BUSY);
  assign rt_nz     = |rt_val;
  assign accept    = is_idle & start & ~flush;

  assign busy     = ~is_idle;
  assign unit_rst = ~is_busy;
  assign stall    = ~is_idle | (accept & rt_nz);

`ifdef MOD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tcnt_q;
  logic          to_q;

  // tcnt_q never passes T_LAST, so it cannot wrap
  assign tmo         = is_busy & (tcnt_q == T_LAST);
  assign timeout_err = to_q;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      tcnt_q <= '0;
      to_q   <= 1'b0;
    end else begin
      if (is_launch)
        tcnt_q <= '0;
      else if (is_busy && tcnt_q != T_LAST)
        tcnt_q <= tcnt_q + 1'b1;
      if (accept)
        to_q <= 1'b0;
      else if (tmo && !flush && !unit_done)
        to_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign tmo            = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lcnt_q    <= '0;
      unit_a    <= '0;
      unit_b    <= '0;
      rem_q     <= '0;
      rem_valid <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      unique case (1'b1)
        is_idle: begin
          if (accept) begin
            unit_a    <= rs_val;
            unit_b    <= rt_val;
            rem_valid <= 1'b0;
            dbz       <= 1'b0;
            lcnt_q    <= '0;
            // divide-by-zero never reaches the unit
            if (!rt_nz) begin
              rem_q     <= rs_val;
              rem_valid <= 1'b1;
              dbz       <= 1'b1;
            end else begin
              state_q <= LAUNCH;
            end
          end
        end
        is_launch: begin
          if (flush)
            state_q <= IDLE;
          else if (lcnt_q == L_LAST)
            state_q <= BUSY;
          else
            lcnt_q <= lcnt_q + 1'b1;
        end
        is_busy: begin
          if (flush) begin
            state_q <= IDLE;
          end else if (unit_done) begin
            rem_q     <= unit_result;
            rem_valid <= 1'b1;
            state_q   <= IDLE;
          end else if (tmo) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_issue_ctrl.sv
// Directed bench for mod_issue_ctrl.
// Inputs change 1ns after posedge, outputs checked at negedge.
module tb_mod_issue_ctrl;

  logic        CLK;
  logic        reset;
  logic        start;
  logic        flush;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic        unit_rst;
  logic        unit_done;
  logic [31:0] unit_result;
  logic        stall;
  logic        busy;
  logic [31:0] rem_q;
  logic        rem_valid;
  logic        dbz;
  logic        timeout_err;

  int n_run;
  int n_fail;

  mod_issue_ctrl #(
    .WIDTH(32),
    .LAUNCH_CYCLES(1),
    .TIMEOUT(8)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .start(start),
    .flush(flush),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .unit_a(unit_a),
    .unit_b(unit_b),
    .unit_rst(unit_rst),
    .unit_done(unit_done),
    .unit_result(unit_result),
    .stall(stall),
    .busy(busy),
    .rem_q(rem_q),
    .rem_valid(rem_valid),
    .dbz(dbz),
    .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic settle;
    @(negedge CLK);
  endtask

  // start an op, done raised on BUSY cycle n with result res
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] res);
    start  = 1'b1;
    rs_val = a;
    rt_val = b;
    settle;
    chk("op_stall_start", stall, 1);
    tick;
    start  = 1'b0;
    rs_val = '0;
    rt_val = '0;
    settle;
    chk("op_unit_a", unit_a, a);
    chk("op_unit_b", unit_b, b);
    chk("op_launch_rst", unit_rst, 1);
    chk("op_launch_valid", rem_valid, 0);
    tick;
    for (int i = 1; i <= n; i++) begin
      if (i == n) begin
        unit_done   = 1'b1;
        unit_result = res;
      end
      settle;
      if (i == 1) chk("op_busy_rst", unit_rst, 0);
      if (i == n) chk("op_done_stall", stall, 1);
      tick;
    end
    unit_done   = 1'b0;
    unit_result = '0;
  endtask

  initial begin
    n_run       = 0;
    n_fail      = 0;
    reset       = 1'b0;
    start       = 1'b0;
    flush       = 1'b0;
    rs_val      = '0;
    rt_val      = '0;
    unit_done   = 1'b0;
    unit_result = '0;

    repeat (2) tick;
    settle;
    chk("rst_unit_rst", unit_rst, 1);
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rem_q", rem_q, 0);
    chk("rst_valid", rem_valid, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_tmo", timeout_err, 0);
    tick;
    reset = 1'b1;
    tick;

    // 17 mod 5, done on 4th BUSY cycle
    run_op(32'd17, 32'd5, 4, 32'd2);
    settle;
    chk("t2_rem_q", rem_q, 2);
    chk("t2_valid", rem_valid, 1);
    chk("t2_stall", stall, 0);
    chk("t2_busy", busy, 0);
    chk("t2_rst", unit_rst, 1);
    chk("t2_dbz", dbz, 0);
    tick;

    // done in first BUSY cycle, then back-to-back 100 mod 7
    run_op(32'd17, 32'd5, 1, 32'd2);
    run_op(32'd100, 32'd7, 2, 32'd2);
    settle;
    chk("t5_rem_q", rem_q, 2);
    chk("t5_valid", rem_valid, 1);
    chk("t5_stall", stall, 0);
    tick;

    // divide by zero
    start  = 1'b1;
    rs_val = 32'd9;
    rt_val = 32'd0;
    settle;
    chk("t3_stall", stall, 0);
    tick;
    start  = 1'b0;
    rs_val = '0;
    settle;
    chk("t3_dbz", dbz, 1);
    chk("t3_rem_q", rem_q, 9);
    chk("t3_valid", rem_valid, 1);
    chk("t3_rst", unit_rst, 1);
    chk("t3_stall2", stall, 0);
    chk("t3_busy", busy, 0);
    tick;

    // flush in 2nd BUSY cycle, racing a done
    start  = 1'b1;
    rs_val = 32'd100;
    rt_val = 32'd7;
    settle;
    tick;
    start  = 1'b0;
    rs_val = '0;
    rt_val = '0;
    settle;
    tick;
    settle;
    tick;
    flush       = 1'b1;
    unit_done   = 1'b1;
    unit_result = 32'd5;
    settle;
    chk("t4_stall", stall, 1);
    tick;
    flush       = 1'b0;
    unit_done   = 1'b0;
    unit_result = '0;
    settle;
    chk("t4_busy", busy, 0);
    chk("t4_valid", rem_valid, 0);
    chk("t4_rem_q", rem_q, 9);
    chk("t4_rst", unit_rst, 1);
    chk("t4_dbz", dbz, 0);
    tick;
    unit_done   = 1'b1;
    unit_result = 32'd2;
    settle;
    tick;
    unit_done   = 1'b0;
    unit_result = '0;
    settle;
    chk("t4_stray_rem_q", rem_q, 9);
    chk("t4_stray_valid", rem_valid, 0);
    chk("t4_stray_busy", busy, 0);
    tick;

    // flush beats start in IDLE
    start  = 1'b1;
    flush  = 1'b1;
    rs_val = 32'd3;
    rt_val = 32'd4;
    settle;
    chk("fs_stall", stall, 0);
    tick;
    start  = 1'b0;
    flush  = 1'b0;
    rs_val = '0;
    rt_val = '0;
    settle;
    chk("fs_busy", busy, 0);
    chk("fs_unit_a", unit_a, 100);
    tick;

    // watchdog
    start  = 1'b1;
    rs_val = 32'd5;
    rt_val = 32'd3;
    settle;
    tick;
    start  = 1'b0;
    rs_val = '0;
    rt_val = '0;
    settle;
    tick;
`ifdef MOD_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      settle;
      if (i == 8) chk("t6_last_stall", stall, 1);
      tick;
    end
    settle;
    chk("t6_busy", busy, 0);
    chk("t6_tmo", timeout_err, 1);
    chk("t6_stall", stall, 0);
    chk("t6_valid", rem_valid, 0);
    tick;
`else
    repeat (100) tick;
    settle;
    chk("t6_stall", stall, 1);
    chk("t6_busy", busy, 1);
    chk("t6_tmo", timeout_err, 0);
    tick;
    flush = 1'b1;
    settle;
    tick;
    flush = 1'b0;
`endif

    // asynchronous reset in BUSY
    start  = 1'b1;
    rs_val = 32'd8;
    rt_val = 32'd3;
    settle;
    tick;
    start  = 1'b0;
    rs_val = '0;
    rt_val = '0;
    settle;
    tick;
    settle;
    chk("t1_pre_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t1_rst", unit_rst, 1);
    chk("t1_stall", stall, 0);
    chk("t1_busy", busy, 0);
    chk("t1_rem_q", rem_q, 0);
    chk("t1_valid", rem_valid, 0);
    chk("t1_dbz", dbz, 0);
    chk("t1_unit_a", unit_a, 0);
    tick;
    reset = 1'b1;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
